// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo disparity sequencer: field widths,
// default frame geometry, FSM state codes and the output saturation helper.
package stereo_pkg;

  localparam int ROW_W      = 9;
  localparam int COL_W      = 9;
  localparam int OFF_W      = 5;
  localparam int WIDTH_DEF  = 320;
  localparam int HEIGHT_DEF = 240;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ISSUE = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_NEXT  = 3'd3;
  localparam state_t S_EMIT  = 3'd4;
  localparam state_t S_ADV   = 3'd5;
  localparam state_t S_DONE  = 3'd6;

  // Clamp the 10-bit scaled disparity into the 8-bit output range.
  function automatic logic [7:0] sat8(input logic [9:0] p);
    return (p > 10'd255) ? 8'hFF : p[7:0];
  endfunction

endpackage

// File: rtl/disp_min_tracker.sv
// Running minimum of SSD cost for the pixel under search. Only a strictly
// smaller cost replaces the stored best, so on ties the earlier (smaller)
// offset survives because offsets are searched in ascending order.
module disp_min_tracker
  import stereo_pkg::*;
#(
  parameter int SSD_W = 21
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [SSD_W-1:0] ssd_i,
  input  logic [OFF_W-1:0] off_i,
  output logic [OFF_W-1:0] best_off_o
);

  logic [SSD_W-1:0] best_ssd_q, best_ssd_d;
  logic [OFF_W-1:0] best_off_q, best_off_d;

  // Clear starts a fresh search; otherwise take a strictly cheaper candidate.
  always_comb begin
    best_ssd_d = best_ssd_q;
    best_off_d = best_off_q;
    if (clr_i) begin
      best_ssd_d = '1;
      best_off_d = '0;
    end else if (upd_i && (ssd_i < best_ssd_q)) begin
      best_ssd_d = ssd_i;
      best_off_d = off_i;
    end
  end

  // Best-so-far registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      best_ssd_q <= '1;
      best_off_q <= '0;
    end else begin
      best_ssd_q <= best_ssd_d;
      best_off_q <= best_off_d;
    end
  end

  assign best_off_o = best_off_q;

endmodule

// File: rtl/disparity_search_ctrl.sv
// Stereo SSD search sequencer: raster-walks the frame, issues one SSD request
// per valid candidate offset, keeps the cheapest and emits a scaled sample.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | present candidate (skipped in one cycle when col < offset)
// WAIT  | request accepted, waiting for the SSD result
// NEXT  | step to next offset or finish the pixel
// EMIT  | present disparity sample downstream
// ADV   | advance raster position, reset search
// DONE  | one-cycle frame_done pulse
module disparity_search_ctrl
  import stereo_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int HEIGHT     = HEIGHT_DEF,
  parameter int MIN_OFFSET = 4,
  parameter int MAX_OFFSET = 10,
  parameter int SSD_W      = 21,
  parameter int SCALE      = 25
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [ROW_W-1:0] req_row,
  output logic [COL_W-1:0] req_col,
  output logic [OFF_W-1:0] req_offset,
  input  logic             rsp_valid,
  input  logic [SSD_W-1:0] rsp_ssd,
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [7:0]       disp_data,
  output logic [ROW_W-1:0] disp_row,
  output logic [COL_W-1:0] disp_col,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [OFF_W-1:0] MIN_OFF  = OFF_W'(MIN_OFFSET);
  localparam logic [OFF_W-1:0] MAX_OFF  = OFF_W'(MAX_OFFSET);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             trk_clr, trk_upd;
  logic [OFF_W-1:0] best_off;
  logic             cand_ok;
  logic [9:0]       prod;

  // A candidate is usable only if the right-image pixel col-offset exists.
  assign cand_ok = (col_q >= COL_W'(off_q));

  // Sequencing and raster position update.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    off_d   = off_q;
    trk_clr = 1'b0;
    trk_upd = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          row_d   = '0;
          col_d   = '0;
          off_d   = MIN_OFF;
          trk_clr = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!cand_ok)       state_d = S_NEXT;
        else if (req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid) begin
          trk_upd = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (off_q < MAX_OFF) begin
          off_d   = off_q + OFF_W'(1);
          state_d = S_ISSUE;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (disp_ready) state_d = S_ADV;
      end
      S_ADV: begin
        off_d   = MIN_OFF;
        trk_clr = 1'b1;
        if ((row_q == LAST_ROW) && (col_q == LAST_COL)) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_DONE;
        end else begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      off_q   <= MIN_OFF;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      off_q   <= off_d;
    end
  end

  disp_min_tracker #(
    .SSD_W (SSD_W)
  ) u_min_tracker (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .clr_i      (trk_clr),
    .upd_i      (trk_upd),
    .ssd_i      (rsp_ssd),
    .off_i      (off_q),
    .best_off_o (best_off)
  );

  // Payloads are zeroed when not valid so idle/reset outputs read as 0.
  assign req_valid  = (state_q == S_ISSUE) && cand_ok;
  assign req_row    = req_valid ? row_q : '0;
  assign req_col    = req_valid ? col_q : '0;
  assign req_offset = req_valid ? off_q : '0;

  assign prod       = 10'(best_off) * 10'(SCALE);
  assign disp_valid = (state_q == S_EMIT);
  assign disp_data  = disp_valid ? sat8(prod) : '0;
  assign disp_row   = disp_valid ? row_q : '0;
  assign disp_col   = disp_valid ? col_q : '0;

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign frame_done = (state_q == S_DONE);

endmodule
